// File: rtl/clz_denorm.sv
// clz_denorm: undoes the leading-zero normalize step. The normalized
// mantissa is shifted right by the LZD count, one barrel stage per clock.
// Stage k handles the count bit of weight 2^k.
// Optional feature: define CLZ_DENORM_STICKY_EN to add the `sticky` output.
// `sticky` is the OR of all bits shifted out past the LSB.
module clz_denorm #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_data,
    input  logic             in_v,
    input  logic [0:CW-1]    in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CLZ_DENORM_STICKY_EN
    output logic             sticky,
`endif
    output logic [0:WIDTH-1] out_data
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    logic [0:WIDTH-1] r_sh;    // working shift register
    logic [0:CW-1]    r_cnt;   // latched shift amount, index 0 = MSB
    logic [CW-1:0]    r_k;     // stage counter
    logic [0:WIDTH-1] r_out;   // result, updated only on entry to DONE
    logic [0:WIDTH-1] w_shifted;
    logic             w_last;
`ifdef CLZ_DENORM_STICKY_EN
    logic             r_stk;
    logic             w_lost;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out;
    assign w_last    = (r_k == CW'(CW - 1));
`ifdef CLZ_DENORM_STICKY_EN
    assign sticky    = r_stk;
`endif

    // One barrel stage: shift by 2^k when count bit of weight 2^k is set.
    // The mux selects on the stage counter, so every shift distance is a constant.
    always_comb begin
        w_shifted = r_sh;
`ifdef CLZ_DENORM_STICKY_EN
        w_lost    = 1'b0;
`endif
        for (int s = 0; s < CW; s++) begin
            if (r_k == CW'(s) && r_cnt[CW-1-s]) begin
                w_shifted = r_sh >> (2**s);
`ifdef CLZ_DENORM_STICKY_EN
                // The low 2^s bits fall off the end; moving them to the top isolates them.
                w_lost    = |(r_sh << (WIDTH - 2**s));
`endif
            end
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_out   <= '0;
`ifdef CLZ_DENORM_STICKY_EN
            r_stk   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
`ifdef CLZ_DENORM_STICKY_EN
                        r_stk <= 1'b0;
`endif
                        if (in_v) begin
                            r_sh    <= in_data;
                            r_cnt   <= in_cnt;
                            r_k     <= '0;
                            r_state <= SHIFT;
                        end else begin
                            // An all-zero source word skips the shifter entirely.
                            r_out   <= '0;
                            r_state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    r_sh <= w_shifted;
                    r_k  <= r_k + 1'b1;
`ifdef CLZ_DENORM_STICKY_EN
                    r_stk <= r_stk | w_lost;
`endif
                    if (w_last) begin
                        r_out   <= w_shifted;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clz_denorm.sv
// Directed bench for clz_denorm at WIDTH=8: expected values hand-computed.
module tb_clz_denorm;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_data;
    logic       in_v;
    logic [0:2] in_cnt;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_data;
`ifdef CLZ_DENORM_STICKY_EN
    logic       sticky;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clz_denorm #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_v      (in_v),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CLZ_DENORM_STICKY_EN
        .sticky    (sticky),
`endif
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word, then count edges from the accept edge until out_valid.
    task automatic start(input logic [7:0] d, input logic v, input logic [2:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_v     = v;
        in_cnt   = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n = 1;
        while (!out_valid && n < 20) begin
            chk({tag, "_busy_rdy"}, 32'(in_ready), 0);
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    task automatic finish_word();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ret_idle_rdy", 32'(in_ready), 1);
        chk("ret_idle_vld", 32'(out_valid), 0);
    endtask

    task automatic run(input string tag, input logic [7:0] d, input logic v, input logic [2:0] c,
                       input logic [7:0] exp, input int lat, input logic stk);
        chk({tag, "_rdy0"}, 32'(in_ready), 1);
        start(d, v, c);
        wait_done(tag, lat);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        chk({tag, "_rdy_done"}, 32'(in_ready), 0);
`ifdef CLZ_DENORM_STICKY_EN
        chk({tag, "_stk"}, 32'(sticky), 32'(stk));
`else
        if (stk === 1'bx) $display("note: unreachable");
`endif
        finish_word();
    endtask

    initial begin
        logic [7:0] held;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_v = 1'b0; in_cnt = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy", 32'(in_ready), 1);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);

        run("c3",   8'b1000_0000, 1'b1, 3'd3, 8'b0001_0000, 4, 1'b0);
        run("c2a",  8'b1011_0011, 1'b1, 3'd2, 8'b0010_1100, 4, 1'b1);
        run("c2b",  8'b1011_0000, 1'b1, 3'd2, 8'b0010_1100, 4, 1'b0);
        run("zero", 8'hFF,        1'b0, 3'd5, 8'h00,        1, 1'b0);
        run("c0",   8'hA5,        1'b1, 3'd0, 8'hA5,        4, 1'b0);
        run("c7",   8'h80,        1'b1, 3'd7, 8'h01,        4, 1'b0);
        run("c5",   8'hC3,        1'b1, 3'd5, 8'h06,        4, 1'b1);

        // Backpressure: hold the result while a new word is offered.
        start(8'hF0, 1'b1, 3'd4);
        wait_done("bp", 4);
        chk("bp_data", 32'(out_data), 32'h0F);
        held = out_data;
        in_valid = 1'b1; in_data = 8'h40; in_v = 1'b1; in_cnt = 3'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", 32'(out_data), 32'(held));
            chk("bp_hold_vld", 32'(out_valid), 1);
            chk("bp_hold_rdy", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_rdy", 32'(in_ready), 1);
        chk("bp_idle_vld", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        chk("bp_accept", 32'(in_ready), 0);
        wait_done("bp2", 4);
        chk("bp2_data", 32'(out_data), 32'h20);
        finish_word();

        // Reset during the second SHIFT cycle discards the word.
        start(8'hF0, 1'b1, 3'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_vld", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_rdy", 32'(in_ready), 1);
        run("post", 8'h0F, 1'b1, 3'd4, 8'h00, 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
